// File: rtl/gearbox_tx.sv
`default_nettype none
// ============================================================================
//  Module      : gearbox_tx
//  Description : 66b -> 64b transmit gearbox. Takes {data, sync header}
//                blocks serialised LSB first and repacks the stream into
//                64b SerDes words. After every 32 accepted blocks the block
//                stalls intake for one cycle to flush the full 64b residual.
//  Revision    : 1.0 - initial release
// ============================================================================
module gearbox_tx #(
    parameter int HEAD_W = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int BLOCK_W = HEAD_W + DATA_W;
    // Working width for {block, residual}: the largest live case is a
    // 66b block on top of a 62b residual, which fits exactly in 128 bits.
    localparam int c_cat_w = 2 * DATA_W;
    localparam logic [5:0] c_seq_wrap = 6'd32;

    // Only the 64b/66b geometry is supported; any other width pair stops
    // elaboration.
    if (HEAD_W != 2 || DATA_W != 64) begin : g_param_check
        $error("gearbox_tx supports only HEAD_W=2 and DATA_W=64");
    end

    logic [5:0]         r_seq;    // blocks accepted in the current 33-word cycle
    logic [DATA_W-1:0]  r_res;    // residual bits, 2*r_seq long, LSB aligned
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;

    logic               w_wrap;
    logic [BLOCK_W-1:0] w_block;
    logic [5:0]         w_shamt;
    logic [c_cat_w-1:0] w_cat;

    assign w_wrap  = (r_seq == c_seq_wrap);
    assign ready_o = !reset && !w_wrap;

    // The residual is kept zero above its valid length, so placing the new
    // block just above it is a shift by the residual length and an OR.
    assign w_block = {data_i, head_i};
    assign w_shamt = {r_seq[4:0], 1'b0};
    assign w_cat   = ({{(c_cat_w - BLOCK_W){1'b0}}, w_block} << w_shamt)
                   | {{(c_cat_w - DATA_W){1'b0}}, r_res};

    assign valid_o = r_valid;
    assign data_o  = r_data;

    // Sequence, residual and output word update: flush on wrap, pack on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq   <= '0;
            r_res   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_wrap) begin
            // Residual holds exactly 64 bits here; valid_i is ignored.
            r_data  <= r_res;
            r_res   <= '0;
            r_seq   <= '0;
            r_valid <= 1'b1;
        end else if (valid_i) begin
            r_data  <= w_cat[DATA_W-1:0];
            r_res   <= w_cat[c_cat_w-1:DATA_W];
            r_seq   <= r_seq + 6'd1;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
